// File: rtl/data_mem_responder.sv
// Single-port data memory that answers one read or write at a time, with a fixed programmable latency.
// Ready pulses for one cycle per access; AddrErr flags word-misaligned accesses alongside Ready.
`timescale 1ns/1ps
module data_mem_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        AddrErr
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] LOAD   = 4'(LATENCY - 1);
    localparam bit         DIRECT = (LATENCY == 1);

    logic [31:0] RAM [2**DEPTH_LOG2];

    state_t                r_state;
    state_t                w_nextState;
    logic [3:0]            r_count;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic                  r_isWrite;
    logic                  r_err;
    logic [31:0]           r_readData;

    logic                  w_req;
    logic                  w_capture;
    logic                  w_enterResp;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_wdata;
    logic                  w_isWrite;
    logic                  w_err;
    logic                  w_unusedAddrBits;

    assign w_req       = MemRead | MemWrite;
    assign w_capture   = (r_state == IDLE) && w_req;
    assign w_enterResp = (w_capture && DIRECT) || ((r_state == BUSY) && (r_count == 4'd1));

    // With LATENCY=1 the commit edge is also the capture edge, so the live inputs are used there.
    assign w_idx     = (r_state == IDLE) ? Address[DEPTH_LOG2+1:2] : r_idx;
    assign w_wdata   = (r_state == IDLE) ? WriteData : r_wdata;
    assign w_isWrite = (r_state == IDLE) ? MemWrite : r_isWrite;
    assign w_err     = (r_state == IDLE) ? (Address[1:0] != 2'b00) : r_err;

    assign w_unusedAddrBits = ^Address[31:DEPTH_LOG2+2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (w_req) w_nextState = DIRECT ? RESP : BUSY;
            BUSY:    if (r_count == 4'd1) w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= 4'd0;
            r_idx      <= '0;
            r_wdata    <= 32'h0;
            r_isWrite  <= 1'b0;
            r_err      <= 1'b0;
            r_readData <= 32'h0;
        end else begin
            if (w_capture) begin
                r_count   <= LOAD;
                r_idx     <= Address[DEPTH_LOG2+1:2];
                r_wdata   <= WriteData;
                r_isWrite <= MemWrite;
                r_err     <= (Address[1:0] != 2'b00);
            end else if (r_state == BUSY) begin
                r_count <= r_count - 4'd1;
            end
            if (w_enterResp && !w_isWrite) begin
                r_readData <= w_err ? 32'h0 : RAM[w_idx];
            end
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_enterResp && w_isWrite && !w_err) begin
            RAM[w_idx] <= w_wdata;
        end
    end

    assign Ready    = (r_state == RESP);
    assign AddrErr  = Ready && r_err;
    assign ReadData = r_readData;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 1, 4) checked against a word-array model.
// Ready is expected high in the cycle sampled LATENCY-1 edges after the capture edge.
`timescale 1ns/1ps
module tb_data_mem_responder;

    logic        clk;
    logic        rst       [3];
    logic        memRead   [3];
    logic        memWrite  [3];
    logic [31:0] address   [3];
    logic [31:0] writeData [3];
    logic [31:0] readData  [3];
    logic        ready     [3];
    logic        addrErr   [3];

    int vecCount  = 0;
    int missCount = 0;

    int          latency  [3] = '{2, 1, 4};
    logic [31:0] modelRam [3][256];
    logic [31:0] modelRd  [3];

    data_mem_responder #(.LATENCY(2), .DEPTH_LOG2(8)) dutL2 (
        .clk(clk), .reset(rst[0]), .MemRead(memRead[0]), .MemWrite(memWrite[0]),
        .Address(address[0]), .WriteData(writeData[0]), .ReadData(readData[0]),
        .Ready(ready[0]), .AddrErr(addrErr[0]));

    data_mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dutL1 (
        .clk(clk), .reset(rst[1]), .MemRead(memRead[1]), .MemWrite(memWrite[1]),
        .Address(address[1]), .WriteData(writeData[1]), .ReadData(readData[1]),
        .Ready(ready[1]), .AddrErr(addrErr[1]));

    data_mem_responder #(.LATENCY(4), .DEPTH_LOG2(8)) dutL4 (
        .clk(clk), .reset(rst[2]), .MemRead(memRead[2]), .MemWrite(memWrite[2]),
        .Address(address[2]), .WriteData(writeData[2]), .ReadData(readData[2]),
        .Ready(ready[2]), .AddrErr(addrErr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete access: model update, drive, junk inputs while busy, check Ready timing and results.
    task automatic doAccess(input int k, input bit rd, input bit wr,
                            input logic [31:0] addr, input logic [31:0] wdata);
        logic [7:0]  idx;
        bit          err;
        logic [31:0] expRd;
        idx = addr[9:2];
        err = (addr[1:0] != 2'b00);
        if (wr) begin
            if (!err) modelRam[k][idx] = wdata;
        end else begin
            modelRd[k] = err ? 32'h0 : modelRam[k][idx];
        end
        expRd = modelRd[k];
        @(negedge clk);
        memRead[k]   = rd;
        memWrite[k]  = wr;
        address[k]   = addr;
        writeData[k] = wdata;
        @(posedge clk); #1;
        memRead[k]   = 1'($urandom_range(0, 1));
        memWrite[k]  = 1'($urandom_range(0, 1));
        address[k]   = $urandom;
        writeData[k] = $urandom;
        for (int e = 1; e < latency[k]; e++) begin
            vecCount++;
            if (ready[k] !== 1'b0 || addrErr[k] !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL busy_quiet L%0d addr=%h: ready=%b addrErr=%b, required 0/0",
                         latency[k], addr, ready[k], addrErr[k]);
            end
            @(posedge clk); #1;
        end
        memRead[k]  = 1'b0;
        memWrite[k] = 1'b0;
        vecCount++;
        if (ready[k] !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL ready_pulse L%0d addr=%h: ready=%b, required 1", latency[k], addr, ready[k]);
        end
        vecCount++;
        if (addrErr[k] !== err) begin
            missCount++;
            $display("[TB] FAIL addr_err L%0d addr=%h: addrErr=%b, required %b", latency[k], addr, addrErr[k], err);
        end
        vecCount++;
        if (readData[k] !== expRd) begin
            missCount++;
            $display("[TB] FAIL read_data L%0d addr=%h: readData=%h, required %h", latency[k], addr, readData[k], expRd);
        end
        @(posedge clk); #1;
        vecCount++;
        if (ready[k] !== 1'b0 || addrErr[k] !== 1'b0 || readData[k] !== expRd) begin
            missCount++;
            $display("[TB] FAIL after_resp L%0d addr=%h: ready=%b addrErr=%b readData=%h, required 0/0/%h",
                     latency[k], addr, ready[k], addrErr[k], readData[k], expRd);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            vecCount++;
            if (ready[k] !== 1'b0 || addrErr[k] !== 1'b0 || readData[k] !== 32'h0) begin
                missCount++;
                $display("[TB] FAIL reset_values L%0d: ready=%b addrErr=%b readData=%h, required 0/0/0",
                         latency[k], ready[k], addrErr[k], readData[k]);
            end
        end
    endtask

    task automatic test_fill();
        logic [31:0] addr;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 256; i++) begin
                addr = $urandom;
                addr[9:0] = {8'(i), 2'b00};
                doAccess(k, 1'($urandom_range(0, 1)), 1'b1, addr, $urandom);
            end
        end
    endtask

    task automatic test_write_read();
        doAccess(0, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF);
        doAccess(0, 1'b1, 1'b0, 32'h80, 32'h0);
    endtask

    // LATENCY=1 with MemRead held high: a pulse every other cycle, addresses taken in order.
    task automatic test_latency1_sweep();
        @(negedge clk);
        memRead[1]  = 1'b1;
        memWrite[1] = 1'b0;
        address[1]  = 32'h0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            modelRd[1] = modelRam[1][j];
            vecCount++;
            if (ready[1] !== 1'b1 || readData[1] !== modelRd[1]) begin
                missCount++;
                $display("[TB] FAIL sweep_pulse j=%0d: ready=%b readData=%h, required 1/%h",
                         j, ready[1], readData[1], modelRd[1]);
            end
            address[1] = 32'(4 * (j + 1));
            if (j == 2) memRead[1] = 1'b0;
            @(posedge clk); #1;
            vecCount++;
            if (ready[1] !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL sweep_gap j=%0d: ready=%b, required 0", j, ready[1]);
            end
        end
    endtask

    task automatic test_misaligned();
        doAccess(0, 1'b0, 1'b1, 32'h80, 32'h11111111);
        doAccess(0, 1'b0, 1'b1, 32'h81, 32'h22222222);
        doAccess(0, 1'b1, 1'b0, 32'h80, 32'h0);
        doAccess(0, 1'b1, 1'b0, 32'h83, 32'h0);
    endtask

    task automatic test_priority_wrap();
        doAccess(0, 1'b1, 1'b0, 32'h80, 32'h0);
        doAccess(0, 1'b1, 1'b1, 32'h400, 32'h5);
        doAccess(0, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_keeps_ram();
        @(negedge clk);
        rst[0] = 1'b1;
        modelRd[0] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        vecCount++;
        if (readData[0] !== 32'h0 || ready[0] !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_clears L2: readData=%h ready=%b, required 0/0", readData[0], ready[0]);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        doAccess(0, 1'b1, 1'b0, 32'h80, 32'h0);
    endtask

    task automatic test_reset_abort();
        doAccess(2, 1'b0, 1'b1, 32'h10, 32'hAAAA5555);
        doAccess(2, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        memWrite[2]  = 1'b1;
        address[2]   = 32'h10;
        writeData[2] = 32'h12345678;
        @(posedge clk); #1;
        memWrite[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst[2] = 1'b1;
        modelRd[2] = 32'h0;
        #1;
        vecCount++;
        if (ready[2] !== 1'b0 || addrErr[2] !== 1'b0 || readData[2] !== 32'h0) begin
            missCount++;
            $display("[TB] FAIL abort_immediate: ready=%b addrErr=%b readData=%h, required 0/0/0",
                     ready[2], addrErr[2], readData[2]);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            vecCount++;
            if (ready[2] !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL abort_no_ready c=%0d: ready=%b, required 0", c, ready[2]);
            end
        end
        @(negedge clk);
        rst[2] = 1'b0;
        doAccess(2, 1'b1, 1'b0, 32'h10, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          op;
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 40; n++) begin
                op   = int'($urandom_range(0, 2));
                addr = $urandom;
                if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
                doAccess(k, op != 1, op != 0, addr, $urandom);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]       = 1'b1;
            memRead[k]   = 1'b0;
            memWrite[k]  = 1'b0;
            address[k]   = 32'h0;
            writeData[k] = 32'h0;
            modelRd[k]   = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        test_fill();
        test_write_read();
        test_latency1_sweep();
        test_misaligned();
        test_priority_wrap();
        test_reset_keeps_ram();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
